// File: rtl/store_monitor.sv
// Store monitor: watches the core's data-memory write port, classifies each
// store as pass / fail / permitted, detects a run timeout, and buffers every
// accepted store record in a first-word-fall-through trace FIFO.
module store_monitor #(
  parameter logic [31:0] PASS_ADDR      = 32'd84,
  parameter logic [31:0] PASS_DATA      = 32'd7,
  parameter logic [31:0] ALLOWED_ADDR   = 32'd80,
  parameter int unsigned TIMEOUT_CYCLES = 20,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  input  logic        trace_ready,
  output logic        trace_valid,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] fail_addr,
  output logic [31:0] fail_data,
  output logic [7:0]  store_count,
  output logic [15:0] cycle_count,
  output logic        overflow
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
  localparam logic [15:0] LastRunCycle = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StRun,
    StPass,
    StFail,
    StTimeout
  } state_e;

  state_e state;

  // Trace FIFO storage and bookkeeping
  logic [31:0]     addr_mem [FIFO_DEPTH];
  logic [31:0]     data_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] fifo_cnt;

  logic in_run;
  logic store;
  logic fifo_full;
  logic pop;
  logic push;
  logic drop;
  logic is_pass_store;
  logic is_bad_store;
  logic at_limit;

  // Store qualification, FIFO handshakes and classification
  always_comb begin
    in_run        = (state == StRun);
    store         = in_run & memwrite;
    fifo_full     = (fifo_cnt == FullCnt);
    pop           = trace_valid & trace_ready;
    // A full FIFO still accepts a push when its head leaves on the same edge.
    push          = store & (~fifo_full | pop);
    drop          = store & fifo_full & ~pop;
    is_pass_store = (dataadr == PASS_ADDR) && (writedata == PASS_DATA);
    is_bad_store  = (dataadr != ALLOWED_ADDR);
    at_limit      = (cycle_count == LastRunCycle);
  end

  // Verdict FSM with registered verdict outputs, counters and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StRun;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      fail_addr   <= '0;
      fail_data   <= '0;
      store_count <= '0;
      cycle_count <= '0;
      overflow    <= 1'b0;
    end else if (state == StRun) begin
      cycle_count <= cycle_count + 16'd1;
      if (drop) begin
        overflow <= 1'b1;
      end
      if (memwrite && (store_count != 8'hFF)) begin
        store_count <= store_count + 8'd1;
      end
      // A terminal store outranks a timeout on the same edge.
      if (memwrite && is_pass_store) begin
        state <= StPass;
        done  <= 1'b1;
        pass  <= 1'b1;
      end else if (memwrite && is_bad_store) begin
        state     <= StFail;
        done      <= 1'b1;
        fail      <= 1'b1;
        fail_addr <= dataadr;
        fail_data <= writedata;
      end else if (at_limit) begin
        state   <= StTimeout;
        done    <= 1'b1;
        timeout <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (depth is a power of two)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CntW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CntW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage; contents are never observed while empty, so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= dataadr;
      data_mem[wr_ptr] <= writedata;
    end
  end

  // Fall-through head, forced to zero when the FIFO is empty
  always_comb begin
    trace_valid = (fifo_cnt != '0);
    trace_addr  = trace_valid ? addr_mem[rd_ptr] : '0;
    trace_data  = trace_valid ? data_mem[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_store_monitor.sv
// Bench for store_monitor: table-driven vectors, directed corner-case
// sequences, and randomized stores checked against a queue-based model.
module tb_store_monitor;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic        trace_ready = 1'b0;
  logic        trace_valid;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic [31:0] fail_addr;
  logic [31:0] fail_data;
  logic [7:0]  store_count;
  logic [15:0] cycle_count;
  logic        overflow;

  store_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .memwrite    (memwrite),
    .dataadr     (dataadr),
    .writedata   (writedata),
    .trace_ready (trace_ready),
    .trace_valid (trace_valid),
    .trace_addr  (trace_addr),
    .trace_data  (trace_data),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
    .fail_addr   (fail_addr),
    .fail_data   (fail_data),
    .store_count (store_count),
    .cycle_count (cycle_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: verdict 0 run, 1 pass, 2 fail, 3 timeout
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } rec_t;

  rec_t        m_q[$];
  int          m_verdict;
  int unsigned m_sc;
  int unsigned m_cc;
  bit          m_ovf;
  logic [31:0] m_fa;
  logic [31:0] m_fd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_verdict = 0;
    m_sc      = 0;
    m_cc      = 0;
    m_ovf     = 0;
    m_fa      = '0;
    m_fd      = '0;
  endtask

  task automatic model_edge(input bit mw, input logic [31:0] a, input logic [31:0] d,
                            input bit rdy);
    bit popped;
    popped = (m_q.size() > 0) && rdy;
    if (popped) void'(m_q.pop_front());
    if (m_verdict == 0) begin
      if (mw) begin
        if (m_sc < 255) m_sc++;
        if (m_q.size() < DEPTH) m_q.push_back('{a, d});
        else m_ovf = 1;
        if (a == 32'd84 && d == 32'd7) begin
          m_verdict = 1;
        end else if (a != 32'd80) begin
          m_verdict = 2;
          m_fa = a;
          m_fd = d;
        end
      end
      if (m_verdict == 0 && m_cc == TMO - 1) m_verdict = 3;
      m_cc++;
    end
  endtask

  task automatic check_model();
    chk("done", 32'(done), 32'(m_verdict != 0));
    chk("pass", 32'(pass), 32'(m_verdict == 1));
    chk("fail", 32'(fail), 32'(m_verdict == 2));
    chk("timeout", 32'(timeout), 32'(m_verdict == 3));
    chk("fail_addr", fail_addr, m_fa);
    chk("fail_data", fail_data, m_fd);
    chk("store_count", 32'(store_count), m_sc);
    chk("cycle_count", 32'(cycle_count), m_cc);
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("trace_valid", 32'(trace_valid), 32'(m_q.size() > 0));
    chk("trace_addr", trace_addr, (m_q.size() > 0) ? m_q[0].a : 32'd0);
    chk("trace_data", trace_data, (m_q.size() > 0) ? m_q[0].d : 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_fail"}, 32'(fail), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_fail_addr"}, fail_addr, 32'd0);
    chk({tag, "_fail_data"}, fail_data, 32'd0);
    chk({tag, "_store_count"}, 32'(store_count), 32'd0);
    chk({tag, "_cycle_count"}, 32'(cycle_count), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_trace_valid"}, 32'(trace_valid), 32'd0);
    chk({tag, "_trace_addr"}, trace_addr, 32'd0);
    chk({tag, "_trace_data"}, trace_data, 32'd0);
  endtask

  // One clock edge: drive inputs, let the edge happen, advance the model,
  // and return at the following falling edge where outputs are sampled.
  task automatic step(input bit mw, input logic [31:0] a, input logic [31:0] d,
                      input bit rdy);
    memwrite    = mw;
    dataadr     = a;
    writedata   = d;
    trace_ready = rdy;
    @(posedge clk);
    model_edge(mw, a, d, rdy);
    @(negedge clk);
  endtask

  // Called at a falling edge; pulses reset well clear of the next rising edge.
  task automatic do_reset();
    memwrite    = 1'b0;
    trace_ready = 1'b0;
    reset       = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit          mw;
    logic [31:0] a;
    logic [31:0] d;
    bit          rdy;
    bit          e_pass;
    bit          e_fail;
    logic [7:0]  e_sc;
    bit          e_valid;
    logic [31:0] e_taddr;
    logic [31:0] e_tdata;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int thr;
    int r;
    bit mw;
    bit rdy;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_d;

    vecs[0] = '{1'b1, 32'd80, 32'd3, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 32'd80, 32'd3};
    vecs[1] = '{1'b1, 32'd84, 32'd7, 1'b0, 1'b1, 1'b0, 8'd2, 1'b1, 32'd80, 32'd3};
    vecs[2] = '{1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 8'd2, 1'b1, 32'd84, 32'd7};
    vecs[3] = '{1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 32'd0, 32'd0};
    vecs[4] = '{1'b1, 32'd76, 32'd5, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 32'd0, 32'd0};

    // Power-on reset held for 22 ns
    model_reset();
    #1;
    chk_zero("por");
    #21;
    reset = 1'b0;

    // Table: pass sequence, in-order drain, terminal state ignores stores
    foreach (vecs[i]) begin
      step(vecs[i].mw, vecs[i].a, vecs[i].d, vecs[i].rdy);
      chk($sformatf("vec%0d_pass", i), 32'(pass), 32'(vecs[i].e_pass));
      chk($sformatf("vec%0d_fail", i), 32'(fail), 32'(vecs[i].e_fail));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_pass | vecs[i].e_fail));
      chk($sformatf("vec%0d_store_count", i), 32'(store_count), 32'(vecs[i].e_sc));
      chk($sformatf("vec%0d_trace_valid", i), 32'(trace_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_trace_addr", i), trace_addr, vecs[i].e_taddr);
      chk($sformatf("vec%0d_trace_data", i), trace_data, vecs[i].e_tdata);
    end

    // Bad address after a permitted store
    do_reset();
    step(1'b1, 32'd80, 32'd1, 1'b0);
    step(1'b1, 32'd76, 32'd5, 1'b0);
    chk("badaddr_fail", 32'(fail), 32'd1);
    chk("badaddr_fail_addr", fail_addr, 32'd76);
    chk("badaddr_fail_data", fail_data, 32'd5);
    chk("badaddr_store_count", 32'(store_count), 32'd2);
    step(1'b1, 32'd84, 32'd7, 1'b0);
    chk("badaddr_late_pass", 32'(pass), 32'd0);
    chk("badaddr_late_count", 32'(store_count), 32'd2);
    chk("badaddr_hold_fail", 32'(fail), 32'd1);

    // Pass address with wrong data
    do_reset();
    step(1'b1, 32'd84, 32'd6, 1'b0);
    chk("wrongdata_fail", 32'(fail), 32'd1);
    chk("wrongdata_pass", 32'(pass), 32'd0);
    chk("wrongdata_fail_addr", fail_addr, 32'd84);
    chk("wrongdata_fail_data", fail_data, 32'd6);

    // Timeout after 20 idle edges
    do_reset();
    repeat (TMO - 1) step(1'b0, 32'd0, 32'd0, 1'b0);
    chk("tmo_early_done", 32'(done), 32'd0);
    chk("tmo_early_cycles", 32'(cycle_count), 32'd19);
    step(1'b0, 32'd0, 32'd0, 1'b0);
    chk("tmo_timeout", 32'(timeout), 32'd1);
    chk("tmo_done", 32'(done), 32'd1);
    chk("tmo_cycles", 32'(cycle_count), 32'd20);
    step(1'b0, 32'd0, 32'd0, 1'b0);
    chk("tmo_cycles_frozen", 32'(cycle_count), 32'd20);

    // Pass store on the timeout edge wins
    do_reset();
    repeat (TMO - 1) step(1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 32'd84, 32'd7, 1'b0);
    chk("tmo_race_pass", 32'(pass), 32'd1);
    chk("tmo_race_timeout", 32'(timeout), 32'd0);
    chk("tmo_race_cycles", 32'(cycle_count), 32'd20);

    // Overflow: 10 stores into an 8-deep FIFO with no consumer
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 32'd80, 32'(i), 1'b0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_store_count", 32'(store_count), 32'd10);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_drain%0d_valid", i), 32'(trace_valid), 32'd1);
      chk($sformatf("ovf_drain%0d_addr", i), trace_addr, 32'd80);
      chk($sformatf("ovf_drain%0d_data", i), trace_data, 32'(i));
      step(1'b0, 32'd0, 32'd0, 1'b1);
    end
    chk("ovf_drained_valid", 32'(trace_valid), 32'd0);

    // Full FIFO: push with concurrent pop is accepted without overflow
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 32'd80, 32'(100 + i), 1'b0);
    chk("fullpop_pre_ovf", 32'(overflow), 32'd0);
    step(1'b1, 32'd80, 32'd200, 1'b1);
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    for (int j = 0; j < 8; j++) begin
      exp_d = (j < 7) ? 32'(101 + j) : 32'd200;
      chk($sformatf("fullpop_drain%0d", j), trace_data, exp_d);
      step(1'b0, 32'd0, 32'd0, 1'b1);
    end
    chk("fullpop_empty", 32'(trace_valid), 32'd0);

    // Asynchronous reset mid-run with three records buffered
    do_reset();
    for (int i = 1; i <= 3; i++) step(1'b1, 32'd80, 32'(i), 1'b0);
    chk("areset_pre_valid", 32'(trace_valid), 32'd1);
    memwrite = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("areset");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step(1'b1, 32'd80, 32'd9, 1'b0);
    step(1'b1, 32'd84, 32'd7, 1'b0);
    chk("areset_resume_pass", 32'(pass), 32'd1);
    chk("areset_resume_count", 32'(store_count), 32'd2);
    chk("areset_resume_head", trace_data, 32'd9);

    // Randomized runs against the reference model
    for (int run = 0; run < 30; run++) begin
      do_reset();
      thr = $urandom_range(0, 4);
      for (int c = 0; c < 45; c++) begin
        mw = ($urandom_range(0, 99) < 60);
        r  = $urandom_range(0, 99);
        if (r < 85) a = 32'd80;
        else if (r < 93) a = 32'd84;
        else a = 32'($urandom_range(0, 127));
        d   = (a == 32'd84) ? 32'($urandom_range(5, 8)) : 32'($urandom_range(0, 15));
        rdy = ($urandom_range(0, 3) < thr);
        step(mw, a, d, rdy);
        check_model();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
